// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared types and default sizes for the programmable
// sequence-detector controller (seq_detect_ctrl + seq_match_core).
//   state_t : controller FSM states, encoding visible on curr_state
//   cfg_t   : configuration latched on the cfg_valid/cfg_ready handshake
// The DEF_* constants size cfg_t and are the defaults of the top-level
// parameters; change them here when building a different geometry.
package seq_ctrl_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned DEF_TIMEOUT = 64;
  localparam int unsigned LEN_W       = $clog2(DEF_MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DEF_MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]       len;
    logic                   overlap;
    logic [DEF_CNT_W-1:0]   target;
  } cfg_t;

endpackage

// File: rtl/seq_detect_ctrl_match_core.sv
// seq_match_core: serial history register, fill counter and masked
// pattern comparator for seq_detect_ctrl.
// Ports:
//   clk, rst       clock / async active-high reset
//   i_clear        clear history and fill (start of a scan)
//   i_shift        accept i_x this cycle
//   i_x            serial data bit
//   i_clear_fill   reset fill instead of advancing it (non-overlap hit)
//   i_pattern      pattern, bit [len-1] is the oldest bit compared
//   i_len          active pattern length, already clamped to 1..MAX_LEN
//   o_hit_c        combinational: the bit being shifted completes a match
module seq_match_core #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic               i_x,
  input  logic               i_clear_fill,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LW-1:0]      i_len,
  output logic               o_hit_c
);

  logic [MAX_LEN-1:0] r_hist;
  logic [LW-1:0]      r_fill;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LW-1:0]      w_fill_next;
  logic [MAX_LEN-1:0] w_mask;

  // Match is evaluated on the post-shift view so y can be registered
  // on the same edge that samples the completing bit.
  always_comb begin
    w_hist_next = {r_hist[MAX_LEN-2:0], i_x};
    w_fill_next = (32'(r_fill) >= MAX_LEN) ? LW'(MAX_LEN) : r_fill + LW'(1);
    w_mask      = '0;
    for (int unsigned k = 0; k < MAX_LEN; k++) begin
      if (k < 32'(i_len)) w_mask[k] = 1'b1;
    end
    o_hit_c = i_shift && (w_fill_next >= i_len) &&
              (((w_hist_next ^ i_pattern) & w_mask) == '0);
  end

  // History/fill register; fill counts bits usable by the next match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= w_hist_next;
      r_fill <= i_clear_fill ? '0 : w_fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial sequence-detector controller.
// Configuration (pattern/len/overlap/target) is taken in IDLE over a
// valid/ready handshake, start launches a scan of the qualified stream
// x/x_valid, each hit pulses y for one cycle and bumps match_cnt, and the
// scan ends on reaching a nonzero target (DONE) or on abort (IDLE).
// Optional build macro SEQ_DETECT_CTRL_TIMEOUT_EN adds a sample watchdog
// that forces DONE after TIMEOUT samples without a hit and raises timeout.
// Ports:
//   clk, rst                     clock / async active-high reset
//   cfg_valid, cfg_ready         configuration handshake (ready only in IDLE)
//   cfg_pattern, cfg_len,        pattern, length (0 or >MAX_LEN -> MAX_LEN),
//   cfg_overlap, cfg_target      overlap enable, stop count (0 = no stop)
//   start, abort                 launch scan from ARMED / end scan
//   x, x_valid                   serial bit and its qualifier
//   y                            registered one-cycle match pulse
//   match_cnt                    saturating match count of current scan
//   busy, done, curr_state       status: ARMED|SCAN, DONE, state encoding
//   timeout                      (macro only) watchdog expired, held in DONE
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic [CNT_W-1:0]             cfg_target,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         x,
  input  logic                         x_valid,
  output logic                         y,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   curr_state
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  ,
  output logic                         timeout
`endif
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  state_t           r_state;
  state_t           w_state_next;
  cfg_t             r_cfg;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_y;
  logic             w_y_next;
  logic             r_cfg_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_latch;
  logic             w_clear_scan;
  logic             w_shift;
  logic             w_hit;
  logic             w_clear_fill;
  logic [LW-1:0]    w_len_in;
  logic [LW-1:0]    w_len_cfg;

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] r_wd;
  logic [WD_W-1:0] w_wd_next;
  logic            r_timeout;
  logic            w_timeout_next;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
`endif

  // Out-of-range lengths fall back to the full register width.
  assign w_len_in  = (cfg_len == '0 || 32'(cfg_len) > MAX_LEN) ? LW'(MAX_LEN) : cfg_len;
  assign w_len_cfg = LW'(r_cfg.len);

  // Abort takes precedence over sampling, so a bit arriving with abort
  // can neither hit nor disturb the history.
  assign w_shift      = (r_state == SCAN) && x_valid && !abort;
  assign w_clear_scan = (r_state == ARMED) && start && !abort;
  assign w_clear_fill = w_hit && !r_cfg.overlap;
  assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LW      (LW)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear_scan),
    .i_shift      (w_shift),
    .i_x          (x),
    .i_clear_fill (w_clear_fill),
    .i_pattern    (MAX_LEN'(r_cfg.pattern)),
    .i_len        (w_len_cfg),
    .o_hit_c      (w_hit)
  );

  // Next-state and next-output decode.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_y_next     = 1'b0;
    w_cnt_next   = r_cnt;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    w_wd_next      = r_wd;
    w_timeout_next = r_timeout;
`endif
    case (r_state)
      IDLE: begin
        if (cfg_valid) begin
          w_latch      = 1'b1;
          w_state_next = ARMED;
        end
      end
      ARMED: begin
        if (abort) begin
          w_state_next = IDLE;
        end else if (start) begin
          w_state_next = SCAN;
          w_cnt_next   = '0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
          w_wd_next    = '0;
`endif
        end
      end
      SCAN: begin
        if (abort) begin
          w_state_next = IDLE;
        end else if (w_hit) begin
          w_y_next   = 1'b1;
          w_cnt_next = w_cnt_inc;
          if (r_cfg.target != '0 && CNT_W'(r_cfg.target) == w_cnt_inc) begin
            w_state_next = DONE;
          end
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
          w_wd_next = '0;
        end else if (x_valid) begin
          if (32'(r_wd) + 32'd1 >= TIMEOUT) begin
            w_state_next   = DONE;
            w_timeout_next = 1'b1;
          end else begin
            w_wd_next = r_wd + WD_W'(1);
          end
`endif
        end
      end
      DONE: begin
        if (cfg_valid || start) begin
          w_state_next = IDLE;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
          w_timeout_next = 1'b0;
`endif
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, configuration, counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cfg       <= '0;
      r_cnt       <= '0;
      r_y         <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
      r_wd        <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_y         <= w_y_next;
      r_cfg_ready <= (w_state_next == IDLE);
      r_busy      <= (w_state_next == ARMED) || (w_state_next == SCAN);
      r_done      <= (w_state_next == DONE);
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
      r_wd        <= w_wd_next;
      r_timeout   <= w_timeout_next;
`endif
      if (w_latch) begin
        r_cfg.pattern <= DEF_MAX_LEN'(cfg_pattern);
        r_cfg.len     <= LEN_W'(w_len_in);
        r_cfg.overlap <= cfg_overlap;
        r_cfg.target  <= DEF_CNT_W'(cfg_target);
      end
    end
  end

  assign cfg_ready  = r_cfg_ready;
  assign y          = r_y;
  assign match_cnt  = r_cnt;
  assign busy       = r_busy;
  assign done       = r_done;
  assign curr_state = r_state;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  assign timeout    = r_timeout;
`endif

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Programmable serial sequence-detector controller.
- Accepts a configuration of pattern, length, overlap mode and target match count through a valid/ready handshake.
- Scans a qualified serial bit stream and pulses a registered match flag on each hit.
- Sequences the scan to completion once the target count is reached; sits in front of the fixed-pattern Moore detectors and replaces per-pattern hardwired FSMs.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (2..16).
- CNT_W, 8: width of the match counter and of the target.
- TIMEOUT, 64: sample count with no match before timeout; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration accepted this cycle if cfg_valid is high; high only in IDLE.
- cfg_pattern  in  MAX_LEN  pattern; cfg_pattern[cfg_len-1] is the first bit received.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cfg_target  in  CNT_W  match count at which the scan ends; 0 = run until abort.
- start  in  1  begin scan (ARMED to SCAN).
- abort  in  1  end scan immediately.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled this cycle.
- y  out  1  registered match pulse, one cycle wide.
- match_cnt  out  CNT_W  matches in the current scan; saturates at all-ones.
- busy  out  1  high in ARMED or SCAN.
- done  out  1  high while in DONE.
- curr_state  out  2  FSM state encoding, for debug.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; y=0, match_cnt=0, done=0, busy=0.
  - cfg_ready=1; history shift register and fill counter cleared.
- FSM states and transitions:
  - IDLE (0): cfg_valid & cfg_ready latches all cfg_* fields, then goes to ARMED. cfg_len outside 1..MAX_LEN is clamped to MAX_LEN.
  - ARMED (1): start goes to SCAN, clearing match_cnt, history and fill. abort goes to IDLE.
  - SCAN (2): on each x_valid, history <= {history[MAX_LEN-2:0], x}; fill increments, saturating at MAX_LEN.
    - Hit when fill_next >= len and history_next[len-1:0] == pattern[len-1:0].
    - On a hit: y=1 next cycle and match_cnt increments.
    - If overlap=0, fill is reset to 0 on the hit, so the hit bits cannot be reused.
    - If the target is nonzero and match_cnt reaches it, go to DONE on that same edge; y still pulses.
  - DONE (3): done=1 and match_cnt is held. The next cycle with cfg_valid or start returns to IDLE; start alone re-enters IDLE only.
- Latency: a bit sampled at edge N produces y=1 during cycle N+1 (Moore-style, registered).
- x_valid=0: history, fill and y are unaffected, except that y always deasserts after one cycle.
- abort in SCAN: goes to IDLE next edge; match_cnt is held for readout and cleared on the next start. abort has priority over a hit in the same cycle: y is not pulsed and the count is not incremented.
- start or cfg_valid in states where they do not apply are ignored.
- Reset mid-scan discards all state, including the latched configuration.

Optional Feature:
- Macro: SEQ_DETECT_CTRL_TIMEOUT_EN.
- Defined:
  - A watchdog counts x_valid samples since the last hit or since start.
  - On reaching TIMEOUT it forces SCAN to DONE and sets output timeout=1 (extra 1-bit port), cleared on leaving DONE.
  - A hit on the same sample as the timeout wins, and the watchdog restarts.
- Undefined: no counter and no timeout port; SCAN exits only on target or abort.

Decomposition:
- Package seq_ctrl_pkg:
  - State enum: IDLE, ARMED, SCAN, DONE.
  - Localparam LEN_W = $clog2(MAX_LEN+1).
  - Config struct: pattern, len, overlap, target.
- One sub-module, seq_match_core:
  - Holds the history shift register, the fill counter and the masked comparator.
  - Exposes hit and takes a clear_fill input.
  - The controller FSM, counter and handshake stay in the top level.

Test Plan:
- Overlap count: pattern=2'b01, len=2, overlap=1, target=0; stream 0,0,1,0,1,0,1,1,0,0,1,0,1,0,1 → six y pulses, one cycle after samples 2,4,6,10,12,14 (0-based); match_cnt=6.
- Other pattern, same stream: pattern=2'b10 → five pulses after samples 3,5,8,11,13; match_cnt=5.
- Overlap mode: pattern=3'b101, len=3; stream 1,0,1,0,1 → overlap=1 gives match_cnt=2, overlap=0 gives match_cnt=1.
- Target stop: target=3, pattern 01 on the first stream → DONE entered on the edge of sample 6; done=1; samples 7..14 do not change match_cnt=3.
- x_valid gaps: x_valid deasserted every other cycle with the 01 stream → same six hits, each y pulse exactly one cycle wide.
- Handshake, abort and reset:
  - cfg_valid held in SCAN → cfg_ready=0 and no relatch.
  - abort coincident with a hit → no y and count unchanged.
  - rst asserted mid-scan → all outputs at reset values asynchronously.
